// File: rtl/tpu_command_feeder.sv
// Byte-stream front end: buffers host bytes in a show-ahead FIFO, assembles them
// into 48-bit TPU command words and issues each one with the execute/busy handshake.
module tpu_command_feeder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CTS_MARGIN  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        cts_o,
  output logic        execute_o,
  output logic [47:0] command_o,
  input  logic        busy_i,
  output logic        overflow_o,
  output logic        bad_opcode_o,
  output logic        timeout_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
  localparam logic [7:0] TPU_PRINT       = 8'h02;
  localparam logic [7:0] TPU_LOCATE      = 8'h03;
  localparam logic [7:0] TPU_SETATTR     = 8'h04;
  localparam logic [7:0] TPU_SETMASK     = 8'h05;

  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, WAIT_ACK, WAIT_DONE} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cts_q, overflow_q;
  logic             empty, full, pop, push;
  logic [7:0]       head;
  logic [2:0]       op_len;

  state_t           state_q;
  logic             execute_q, bad_opcode_q, timeout_q;
  logic [47:0]      command_q;
  logic [1:0]       rem_q, idx_q;
  logic [TO_W-1:0]  ack_cnt_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign pop   = !empty && (state_q == FETCH_OP || state_q == FETCH_ARG);
  // A pop on the same edge frees the slot, so a full FIFO can still take the byte.
  assign push  = rx_valid_i && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    case (head)
      TPU_CLEARSCREEN: op_len = 3'd1;
      TPU_PRINT:       op_len = 3'd2;
      TPU_LOCATE:      op_len = 3'd3;
      TPU_SETATTR:     op_len = 3'd3;
      TPU_SETMASK:     op_len = 3'd4;
      default:         op_len = 3'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cts_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      cts_q   <= (CNT_W'(FIFO_DEPTH) - count_d) > CNT_W'(CTS_MARGIN);
      if (rx_valid_i && !push)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FETCH_OP;
      execute_q    <= 1'b0;
      bad_opcode_q <= 1'b0;
      timeout_q    <= 1'b0;
      command_q    <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      ack_cnt_q    <= '0;
    end else begin
      execute_q    <= 1'b0;
      bad_opcode_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        FETCH_OP: begin
          if (!empty) begin
            if (op_len == 3'd0) begin
              bad_opcode_q <= 1'b1;
            end else begin
              command_q <= {40'd0, head};
              if (op_len == 3'd1) begin
                execute_q <= 1'b1;
                ack_cnt_q <= '0;
                state_q   <= WAIT_ACK;
              end else begin
                rem_q   <= 2'(op_len - 3'd1);
                idx_q   <= 2'd1;
                state_q <= FETCH_ARG;
              end
            end
          end
        end
        FETCH_ARG: begin
          if (!empty) begin
            command_q[{idx_q, 3'b000} +: 8] <= head;
            idx_q <= idx_q + 2'd1;
            rem_q <= rem_q - 2'd1;
            if (rem_q == 2'd1) begin
              execute_q <= 1'b1;
              ack_cnt_q <= '0;
              state_q   <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (busy_i) begin
            state_q <= WAIT_DONE;
          end else if (ack_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= FETCH_OP;
          end else begin
            ack_cnt_q <= ack_cnt_q + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!busy_i)
            state_q <= FETCH_OP;
        end
        default: state_q <= FETCH_OP;
      endcase
    end
  end

  assign cts_o        = cts_q;
  assign overflow_o   = overflow_q;
  assign execute_o    = execute_q;
  assign command_o    = command_q;
  assign bad_opcode_o = bad_opcode_q;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_tpu_command_feeder.sv
// Bench for tpu_command_feeder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed command words and timings.
module tb_tpu_command_feeder;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int ACKTO  = 4;
  localparam logic [7:0] OP_CLS    = 8'h01;
  localparam logic [7:0] OP_PRINT  = 8'h02;
  localparam logic [7:0] OP_LOCATE = 8'h03;
  localparam logic [7:0] OP_ATTR   = 8'h04;
  localparam logic [7:0] OP_MASK   = 8'h05;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        busy = 1'b0;
  logic        cts, execute, overflow, bad_opcode, timeout;
  logic [47:0] command;

  always #5 clk = ~clk;

  tpu_command_feeder #(.FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN), .ACK_TIMEOUT(ACKTO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .cts_o(cts), .execute_o(execute), .command_o(command), .busy_i(busy),
    .overflow_o(overflow), .bad_opcode_o(bad_opcode), .timeout_o(timeout)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_ovf;
  int          m_phase;   // 0: taking bytes, 1: awaiting busy, 2: TPU working
  int          m_need, m_got, m_wait;
  logic        e_exec, e_bad, e_to, e_cts;
  logic [47:0] e_cmd;

  function automatic int cmd_len(input logic [7:0] op);
    case (op)
      OP_CLS:    return 1;
      OP_PRINT:  return 2;
      OP_LOCATE: return 3;
      OP_ATTR:   return 3;
      OP_MASK:   return 4;
      default:   return 0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_phase = 0; m_need = 0; m_got = 0; m_wait = 0;
    e_exec = 0; e_bad = 0; e_to = 0; e_cts = 1; e_cmd = '0;
  endtask

  task automatic model_step();
    bit         took;
    logic [7:0] b;
    took = (m_phase == 0) && (mq.size() > 0);
    b = 8'h00;
    e_exec = 0; e_bad = 0; e_to = 0;
    if (took) b = mq.pop_front();
    if (rx_valid) begin
      if (mq.size() < DEPTH) mq.push_back(rx_data);
      else m_ovf = 1;
    end
    if (m_phase == 1) begin
      if (busy) m_phase = 2;
      else begin
        m_wait++;
        if (m_wait == ACKTO) begin e_to = 1; m_phase = 0; end
      end
    end else if (m_phase == 2) begin
      if (!busy) m_phase = 0;
    end else if (took) begin
      if (m_need == 0) begin
        m_need = cmd_len(b);
        if (m_need == 0) e_bad = 1;
        else begin e_cmd = {40'd0, b}; m_got = 1; end
      end else begin
        e_cmd[8*m_got +: 8] = b;
        m_got++;
      end
      if (m_need != 0 && m_got == m_need) begin
        e_exec = 1; m_phase = 1; m_wait = 0; m_need = 0;
      end
    end
    e_cts = (DEPTH - mq.size()) > MARGIN;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- TPU stand-in: busy for busy_len cycles after execute ----------------
  int busy_len = 1;
  int busy_cnt = 0;
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin busy = 0; busy_cnt = 0; end
    else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy = 0;
    end else if (execute && busy_len > 0) begin
      busy = 1; busy_cnt = busy_len;
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  logic [47:0] ex_cmd[$];
  int          ex_cyc[$];
  int          bad_n = 0;
  int          to_cyc = -1;

  initial forever begin
    @(negedge clk);
    check("execute", execute, e_exec);
    check("command", command, e_cmd);
    check("cts", cts, e_cts);
    check("overflow", overflow, m_ovf);
    check("bad_opcode", bad_opcode, e_bad);
    check("timeout", timeout, e_to);
    if (execute) begin
      ex_cmd.push_back(command);
      ex_cyc.push_back(cyc);
      $display("execute #%0d cycle %0d command %012h", ex_cmd.size() - 1, cyc, command);
    end
    if (bad_opcode) begin bad_n++; $display("bad_opcode cycle %0d", cyc); end
    if (timeout) begin to_cyc = cyc; $display("timeout cycle %0d", cyc); end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_exec(input int target, input int budget);
    int k;
    k = 0;
    while (ex_cmd.size() < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check("wait_exec_count", ex_cmd.size(), target);
  endtask

  initial begin
    logic [7:0] msg[5];
    int e_wr;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    #1 rst_n = 1'b0;
    idle(2);
    check("rst_cts", cts, 1'b1);
    check("rst_execute", execute, 1'b0);
    check("rst_command", command, 48'h0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // LOCATE back-to-back, execute one cycle after the final write edge
    send(OP_LOCATE); send(8'h05); send(8'h0A);
    e_wr = cyc;
    wait_exec(1, 20);
    check("locate_cmd", ex_cmd[0], 48'h0000_000A_0503);
    check("locate_latency", ex_cyc[0], e_wr + 1);
    idle(5);
    check("locate_single", ex_cmd.size(), 1);

    // unknown opcode then a valid PRINT
    send(8'hFF);
    idle(3);
    check("bad_count", bad_n, 1);
    check("bad_no_exec", ex_cmd.size(), 1);
    send(OP_PRINT); send(8'h41);
    wait_exec(2, 20);
    check("print_after_bad", ex_cmd[1], 48'h0000_0000_4102);

    // busy tied low: timeout exactly ACKTO cycles after execute
    busy_len = 0;
    send(OP_CLS);
    wait_exec(3, 20);
    idle(8);
    check("cls_cmd", ex_cmd[2], 48'h0000_0000_0001);
    check("timeout_gap", to_cyc - ex_cyc[2], ACKTO);
    busy_len = 1;
    send(OP_PRINT); send(8'h5A);
    wait_exec(4, 20);
    check("print_after_timeout", ex_cmd[3], 48'h0000_0000_5A02);

    // CLEARSCREEN with a long busy, five PRINTs buffered meanwhile
    busy_len = 6000;
    send(OP_CLS);
    wait_exec(5, 20);
    busy_len = 1;
    for (int i = 0; i < 5; i++) begin send(OP_PRINT); send(msg[i]); end
    check("buffered_cts", cts, 1'b1);
    check("buffered_no_exec", ex_cmd.size(), 5);
    wait_exec(10, 7000);
    for (int i = 0; i < 5; i++) check("hello_cmd", ex_cmd[5+i], {32'd0, msg[i], OP_PRINT});
    check("issue_gap", ex_cyc[7] - ex_cyc[6], 4);

    // 18 bytes while the TPU is busy: 17th overflows, 16 retained
    busy_len = 200;
    send(OP_CLS);
    wait_exec(11, 20);
    busy_len = 1;
    for (int k = 1; k <= 18; k++) begin
      if (k % 2 == 1) send(OP_PRINT);
      else send(8'h61 + 8'((k / 2) - 1));
      if (k == 11) check("cts_at_11", cts, 1'b1);
      if (k == 12) check("cts_at_12", cts, 1'b0);
      if (k == 16) check("ovf_at_16", overflow, 1'b0);
      if (k == 17) check("ovf_at_17", overflow, 1'b1);
    end
    wait_exec(19, 600);
    for (int i = 0; i < 8; i++) check("ovf_print", ex_cmd[11+i], {32'd0, 8'h61 + 8'(i), OP_PRINT});
    idle(20);
    check("ovf_dropped", ex_cmd.size(), 19);
    check("ovf_sticky", overflow, 1'b1);

    // reset during WAIT_DONE with 5 bytes buffered
    busy_len = 300;
    send(OP_CLS);
    wait_exec(20, 20);
    send(OP_PRINT); send(8'h61); send(OP_PRINT); send(8'h62); send(OP_CLS);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_execute", execute, 1'b0);
    check("arst_command", command, 48'h0);
    check("arst_cts", cts, 1'b1);
    check("arst_overflow", overflow, 1'b0);
    check("arst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    check("arst_no_exec", ex_cmd.size(), 20);
    check("arst_cts_after", cts, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
